fpu_stall_ctrl: RTL and testbench
=================================

// Module: fpu_stall_ctrl
// PURPOSE
//  Consumes fpucontrol/fpustall from the FP decoder and sequences multi-cycle FPU ops in EX.
//  Holds the pipeline (stall) for the latency class given by fpustall, freezes the op code
//  to the FPU while busy, and pulses fp_done when the FPU result may be written back.
//  Sits between the FP decoder/EX stage and the hazard unit; the FPU datapath is external.
// PARAMETERS
//  LAT_SHORT  2   stall cycles for fpustall=01 (fadd/fsub/fmul/floor/ftoi/itof)
//  LAT_SQRT   6   stall cycles for fpustall=10 (fsqrt)
//  LAT_DIV    10  stall cycles for fpustall=11 (fdiv)
//  CNT_W      4   latency counter width; each LAT_* in 1..2^CNT_W-1
//  STAT_W     32  width of stall-cycle statistics counter
// PORTS
//  clk          in   1       clock, all state on rising edge
//  rstn         in   1       synchronous reset, active low
//  issue        in   1       valid FP instruction (op=010001) present in EX this cycle
//  flush        in   1       EX instruction squashed (branch/exception)
//  fpucontrol   in   4       op code from FP decoder
//  fpustall     in   2       latency class from FP decoder (00/01/10/11)
//  fpu_op       out  4       op code driven to FPU
//  fpu_start    out  1       one-cycle pulse: FPU latches operands
//  stall        out  1       freeze IF/ID/EX this cycle
//  busy         out  1       multi-cycle op in progress (state BUSY)
//  fp_done      out  1       one-cycle pulse: FPU result valid, write back
//  stall_cycles out  STAT_W  total cycles with stall=1, saturating
// BEHAVIOUR
//  States: IDLE, BUSY, DONE. Registers: state, cnt[CNT_W], op_q[4], stall_cycles.
//  Reset (rstn=0 at edge): state=IDLE, cnt=0, op_q=0, stall_cycles=0. While rstn=0 all
//   outputs forced 0 (fpu_op=0, stall=0, fp_done=0, fpu_start=0, busy=0) regardless of inputs.
//  N(code): 00->0, 01->LAT_SHORT, 10->LAT_SQRT, 11->LAT_DIV.
//  IDLE: fpu_op=fpucontrol (pass-through).
//   issue&!flush&fpustall==00: fp_done=1 same cycle, stall=0, stay IDLE (feq/fless, 0 latency).
//   issue&!flush&fpustall!=00: stall=1, fpu_start=1, op_q<=fpucontrol;
//    N==1 -> DONE; else cnt<=N-1, -> BUSY.
//   !issue or flush: no outputs, stay IDLE.
//  BUSY: stall=1, busy=1, fpu_op=op_q; inputs fpucontrol/fpustall ignored.
//   flush -> IDLE (no fp_done; stall still 1 in that cycle); else cnt==1 -> DONE, else cnt--.
//  DONE: stall=0, fp_done=1, fpu_op=op_q; issue ignored (same instr, must not retrigger);
//   flush suppresses fp_done; always -> IDLE next cycle.
//  Timing: issue at cycle T with class N>=1 -> stall=1 for cycles T..T+N-1 exactly,
//   fp_done at T+N, back-to-back FP op may issue at T+N+1.
//  stall_cycles += 1 each cycle stall=1, saturates at 2^STAT_W-1, cleared only by reset.
//  fpustall=00 with fpucontrol=xxxx (undefined funct): treated as 0-latency, fp_done pulses.
//  Reset mid-op: op abandoned, no fp_done, IDLE after the reset edge.
// TESTING
//  fadd: issue=1,fpustall=01 at T (LAT_SHORT=2) -> stall=1 T,T+1; fp_done=1 at T+2 only;
//   fpu_start=1 only at T.
//  fdiv: fpustall=11, fpucontrol=0011 at T; fpucontrol driven 0000 from T+1 -> fpu_op=0011
//   through T+10; stall 10 cycles; fp_done at T+10.
//  feq: fpustall=00, fpucontrol=1000 -> fp_done=1 same cycle, stall=0, state stays IDLE.
//  fsqrt with flush=1 at T+3 -> stall drops at T+4, no fp_done; next issue at T+4 accepted.
//  Back-to-back fmul,fmul (issue held high) -> fp_done at T+2 and T+5; no retrigger in DONE;
//   stall_cycles=4 afterwards.
//  rstn=0 at T+2 of fdiv -> all outputs 0 from T+2 while low; IDLE and stall_cycles=0 after.

Source files
------------

// File: rtl/fpu_stall_ctrl_if.sv
// Handshake bundle between the FP decoder/EX stage and the FPU stall controller.
// The master side is the EX stage (drives instruction info), the slave side is
// the controller (drives FPU sequencing and pipeline hold).
interface fpu_stall_ctrl_if #(
  parameter int STAT_W = 32
);
  logic              issue;
  logic              flush;
  logic [3:0]        fpucontrol;
  logic [1:0]        fpustall;
  logic [3:0]        fpu_op;
  logic              fpu_start;
  logic              stall;
  logic              busy;
  logic              fp_done;
  logic [STAT_W-1:0] stall_cycles;

  modport master (
    output issue, flush, fpucontrol, fpustall,
    input  fpu_op, fpu_start, stall, busy, fp_done, stall_cycles
  );

  modport slave (
    input  issue, flush, fpucontrol, fpustall,
    output fpu_op, fpu_start, stall, busy, fp_done, stall_cycles
  );
endinterface

// File: rtl/fpu_stall_ctrl.sv
// FPU stall controller: sequences multi-cycle FP ops in EX. Holds the pipeline
// for the latency class of the issued op, freezes the op code to the FPU while
// busy and pulses fp_done when the result may be written back.
// Outputs react to issue/flush in the same cycle so the hazard unit sees the
// stall in the issue cycle itself.
module fpu_stall_ctrl #(
  parameter int LAT_SHORT = 2,
  parameter int LAT_SQRT  = 6,
  parameter int LAT_DIV   = 10,
  parameter int CNT_W     = 4,
  parameter int STAT_W    = 32
) (
  input  logic              clk,
  input  logic              rstn,
  fpu_stall_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [3:0]        op_q;
  logic [STAT_W-1:0] stall_cnt;

  logic              accept;
  logic [CNT_W-1:0]  lat_n;
  logic              stall_int;

  // Stall cycles for a latency class; class 00 is the zero-latency compare group.
  function automatic logic [CNT_W-1:0] lat_of(input logic [1:0] code);
    case (code)
      2'b01:   lat_of = CNT_W'(LAT_SHORT);
      2'b10:   lat_of = CNT_W'(LAT_SQRT);
      2'b11:   lat_of = CNT_W'(LAT_DIV);
      default: lat_of = '0;
    endcase
  endfunction

  assign accept = bus.issue & ~bus.flush;
  assign lat_n  = lat_of(bus.fpustall);

  // Output decode from state and EX inputs; everything is held at 0 while in reset.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    bus.fpu_op       = '0;
    bus.fpu_start    = 1'b0;
    bus.busy         = 1'b0;
    bus.fp_done      = 1'b0;
    bus.stall_cycles = '0;
    stall_int        = 1'b0;
    if (rstn) begin
      bus.stall_cycles = stall_cnt;
      case (state)
        IDLE: begin
          bus.fpu_op = bus.fpucontrol;
          if (accept) begin
            if (bus.fpustall == 2'b00) begin
              bus.fp_done = 1'b1;
            end else begin
              stall_int     = 1'b1;
              bus.fpu_start = 1'b1;
            end
          end
        end
        BUSY: begin
          bus.fpu_op = op_q;
          bus.busy   = 1'b1;
          stall_int  = 1'b1;
        end
        DONE: begin
          // Issue is the same instruction still sitting in EX; only flush matters.
          bus.fpu_op  = op_q;
          bus.fp_done = ~bus.flush;
        end
        default: ;
      endcase
    end
  end

  assign bus.stall = stall_int;

  // Sequencer state, latched op code, latency countdown and stall statistics.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      op_q      <= '0;
      stall_cnt <= '0;
    end else begin
      if (stall_int && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      case (state)
        IDLE: begin
          if (accept && (bus.fpustall != 2'b00)) begin
            op_q <= bus.fpucontrol;
            if (lat_n == CNT_W'(1)) begin
              state <= DONE;
            end else begin
              cnt   <= lat_n - 1'b1;
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (bus.flush) begin
            state <= IDLE;
          end else if (cnt == CNT_W'(1)) begin
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_stall_ctrl.sv
// Self-checking bench for fpu_stall_ctrl. Write-back events are predicted when
// an op is issued (cycle and op code) and matched when fp_done pulses.
module tb_fpu_stall_ctrl;

  localparam int LAT_SHORT = 2;
  localparam int LAT_SQRT  = 6;
  localparam int LAT_DIV   = 10;
  localparam int STAT_W    = 32;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  fpu_stall_ctrl_if #(.STAT_W(STAT_W)) bus ();

  fpu_stall_ctrl #(
    .LAT_SHORT (LAT_SHORT),
    .LAT_SQRT  (LAT_SQRT),
    .LAT_DIV   (LAT_DIV),
    .CNT_W     (4),
    .STAT_W    (STAT_W)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] op;
  } exp_t;

  exp_t sb[$];
  exp_t got_e;
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   exp_stall = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int lat_of(input logic [1:0] cls);
    case (cls)
      2'b01:   return LAT_SHORT;
      2'b10:   return LAT_SQRT;
      2'b11:   return LAT_DIV;
      default: return 0;
    endcase
  endfunction

  // Write-back monitor: every fp_done pulse must match the oldest prediction.
  always @(negedge clk) begin
    if (rstn && bus.fp_done === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_done", 64'd1, 64'd0);
      end else begin
        got_e = sb.pop_front();
        check("done_cycle", 64'(cyc), 64'(got_e.cyc));
        check("done_op", 64'(bus.fpu_op), 64'(got_e.op));
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.issue      = 1'b0;
    bus.flush      = 1'b0;
    bus.fpucontrol = 4'h0;
    bus.fpustall   = 2'b00;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_stall"}, 64'(bus.stall), 64'd0);
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_start"}, 64'(bus.fpu_start), 64'd0);
  endtask

  // Issue one op for a single cycle and follow it to write-back, scrambling
  // the decoder inputs while the op is in flight.
  task automatic run_op(input logic [3:0] op, input logic [1:0] cls, input string name);
    int n;
    n = lat_of(cls);
    bus.issue      = 1'b1;
    bus.flush      = 1'b0;
    bus.fpucontrol = op;
    bus.fpustall   = cls;
    sb.push_back('{cyc + n, op});
    exp_stall += n;
    @(negedge clk);
    check({name, "_issue_stall"}, 64'(bus.stall), 64'(n > 0));
    check({name, "_issue_start"}, 64'(bus.fpu_start), 64'(n > 0));
    check({name, "_issue_busy"}, 64'(bus.busy), 64'd0);
    next_cycle();
    bus.issue      = 1'b0;
    bus.fpucontrol = 4'($urandom);
    bus.fpustall   = 2'($urandom);
    for (int k = 1; k < n; k++) begin
      @(negedge clk);
      check({name, "_busy_stall"}, 64'(bus.stall), 64'd1);
      check({name, "_busy_busy"}, 64'(bus.busy), 64'd1);
      check({name, "_busy_start"}, 64'(bus.fpu_start), 64'd0);
      check({name, "_busy_op"}, 64'(bus.fpu_op), 64'(op));
      next_cycle();
    end
    if (n > 0) begin
      @(negedge clk);
      check({name, "_done_stall"}, 64'(bus.stall), 64'd0);
      check({name, "_done_busy"}, 64'(bus.busy), 64'd0);
      next_cycle();
    end
    drive_idle();
  endtask

  initial begin
    // Reset with live-looking inputs: everything must read 0.
    bus.issue      = 1'b1;
    bus.flush      = 1'b0;
    bus.fpucontrol = 4'h5;
    bus.fpustall   = 2'b11;
    #1;
    @(negedge clk);
    check("rst_stall", 64'(bus.stall), 64'd0);
    check("rst_start", 64'(bus.fpu_start), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.fp_done), 64'd0);
    check("rst_op", 64'(bus.fpu_op), 64'd0);
    next_cycle();
    rstn = 1'b1;
    drive_idle();
    @(negedge clk);
    check("rst_stat", 64'(bus.stall_cycles), 64'd0);
    check_quiet("post_rst");
    next_cycle();

    run_op(4'h0, 2'b01, "fadd");
    run_op(4'h3, 2'b11, "fdiv");
    run_op(4'h8, 2'b00, "feq");
    run_op(4'bxxxx, 2'b00, "undef");
    run_op(4'h4, 2'b10, "fsqrt");

    // Flushed issue in IDLE: nothing happens.
    bus.issue = 1'b1; bus.flush = 1'b1; bus.fpucontrol = 4'h2; bus.fpustall = 2'b01;
    @(negedge clk);
    check_quiet("flush_idle");
    next_cycle();
    bus.fpustall = 2'b00;
    next_cycle();
    drive_idle();
    @(negedge clk);
    check_quiet("flush_idle_after");
    next_cycle();

    // fsqrt flushed at T+3, new issue accepted at T+4.
    bus.issue = 1'b1; bus.fpucontrol = 4'h4; bus.fpustall = 2'b10;
    exp_stall += 4;
    @(negedge clk);
    check("sqflush_t0_stall", 64'(bus.stall), 64'd1);
    next_cycle();
    drive_idle();
    for (int k = 1; k < 3; k++) begin
      @(negedge clk);
      check("sqflush_stall", 64'(bus.stall), 64'd1);
      next_cycle();
    end
    bus.flush = 1'b1;
    @(negedge clk);
    check("sqflush_t3_stall", 64'(bus.stall), 64'd1);
    check("sqflush_t3_busy", 64'(bus.busy), 64'd1);
    next_cycle();
    run_op(4'h1, 2'b01, "after_flush");

    // Flush in DONE suppresses write-back; issue held must not retrigger.
    bus.issue = 1'b1; bus.fpucontrol = 4'h6; bus.fpustall = 2'b01;
    exp_stall += 2;
    next_cycle();
    bus.issue = 1'b0;
    next_cycle();
    bus.issue = 1'b1; bus.flush = 1'b1;
    @(negedge clk);
    check("done_flush_done", 64'(bus.fp_done), 64'd0);
    check("done_flush_stall", 64'(bus.stall), 64'd0);
    check("done_flush_start", 64'(bus.fpu_start), 64'd0);
    next_cycle();
    drive_idle();
    @(negedge clk);
    check_quiet("done_flush_after");
    check("stat_total", 64'(bus.stall_cycles), 64'(exp_stall));
    next_cycle();

    // Reset two cycles into an fdiv.
    bus.issue = 1'b1; bus.fpucontrol = 4'h3; bus.fpustall = 2'b11;
    next_cycle();
    drive_idle();
    next_cycle();
    rstn = 1'b0;
    bus.issue = 1'b1; bus.fpucontrol = 4'hf; bus.fpustall = 2'b11;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("midrst_stall", 64'(bus.stall), 64'd0);
      check("midrst_busy", 64'(bus.busy), 64'd0);
      check("midrst_done", 64'(bus.fp_done), 64'd0);
      check("midrst_start", 64'(bus.fpu_start), 64'd0);
      check("midrst_op", 64'(bus.fpu_op), 64'd0);
      next_cycle();
    end
    rstn = 1'b1;
    drive_idle();
    exp_stall = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check_quiet("midrst_after");
      check("midrst_stat", 64'(bus.stall_cycles), 64'd0);
      next_cycle();
    end

    // Back-to-back fmul with issue held high.
    bus.issue = 1'b1; bus.fpucontrol = 4'h2; bus.fpustall = 2'b01;
    sb.push_back('{cyc + 2, 4'h2});
    @(negedge clk);
    check("b2b_t0_start", 64'(bus.fpu_start), 64'd1);
    next_cycle();
    @(negedge clk);
    check("b2b_t1_stall", 64'(bus.stall), 64'd1);
    next_cycle();
    @(negedge clk);
    check("b2b_t2_stall", 64'(bus.stall), 64'd0);
    check("b2b_t2_start", 64'(bus.fpu_start), 64'd0);
    next_cycle();
    sb.push_back('{cyc + 2, 4'h2});
    @(negedge clk);
    check("b2b_t3_stall", 64'(bus.stall), 64'd1);
    check("b2b_t3_start", 64'(bus.fpu_start), 64'd1);
    next_cycle();
    bus.issue = 1'b0;
    @(negedge clk);
    check("b2b_t4_stall", 64'(bus.stall), 64'd1);
    next_cycle();
    @(negedge clk);
    check("b2b_t5_stall", 64'(bus.stall), 64'd0);
    next_cycle();
    drive_idle();
    @(negedge clk);
    check_quiet("b2b_after");
    check("b2b_stat", 64'(bus.stall_cycles), 64'd4);
    next_cycle();
    repeat (2) next_cycle();

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
